// File: rtl/amo_pkg.sv
// amo_pkg: shared types, AMO encodings and reservation granule helper
package amo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        KIND_LR  = 2'd0,
        KIND_SC  = 2'd1,
        KIND_AMO = 2'd2
    } req_kind_t;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    localparam logic [3:0] ALU_AMO = 4'b1110;

    function automatic logic same_granule(input logic [63:0] a, input logic [63:0] b, input int unsigned g);
        return (a >> g) == (b >> g);
    endfunction

endpackage

// File: rtl/amo_sequencer_if.sv
// amo_sequencer_if: request, memory, ALU, snoop and writeback signals of the AMO sequencer
interface amo_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    import amo_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    req_kind_t             req_kind;
    logic [4:0]            req_amo_op;
    logic                  req_word;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [4:0]            req_rd;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic                  mem_req_word;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;
    logic [DATA_WIDTH-1:0] alu_operand_a;
    logic [DATA_WIDTH-1:0] alu_operand_b;
    logic [4:0]            alu_amo_op;
    logic                  alu_word;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  snoop_valid;
    logic [ADDR_WIDTH-1:0] snoop_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [4:0]            resp_rd;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_fault;
    logic                  resv_valid;

    modport slave (
        input  req_valid, req_kind, req_amo_op, req_word, req_addr, req_data, req_rd,
        output req_ready,
        output mem_req_valid, mem_req_we, mem_req_word, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output alu_operand_a, alu_operand_b, alu_amo_op, alu_word,
        input  alu_result,
        input  snoop_valid, snoop_addr,
        output resp_valid, resp_rd, resp_data, resp_fault,
        input  resp_ready,
        output resv_valid
    );

    modport master (
        output req_valid, req_kind, req_amo_op, req_word, req_addr, req_data, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_req_we, mem_req_word, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  alu_operand_a, alu_operand_b, alu_amo_op, alu_word,
        output alu_result,
        output snoop_valid, snoop_addr,
        input  resp_valid, resp_rd, resp_data, resp_fault,
        output resp_ready,
        input  resv_valid
    );

endinterface

// File: rtl/amo_reservation.sv
// amo_reservation: single LR reservation with set/clear, snoop kill and granule match
module amo_reservation
    import amo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int GRANULE_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic [ADDR_WIDTH-1:0] match_addr,
    input  logic                  snoop_valid,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  valid,
    output logic                  match
);

    logic [ADDR_WIDTH-1:0] resv_addr;
    logic                  snoop_kill;

    // a snoop hitting the held granule overrides any concurrent match
    always_comb begin
        snoop_kill = valid && snoop_valid && same_granule(snoop_addr, resv_addr, GRANULE_LOG2);
        match = valid && !snoop_kill && same_granule(match_addr, resv_addr, GRANULE_LOG2);
    end

    // set overwrites the old reservation unless a snoop hits the new granule that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            resv_addr <= '0;
        end else if (set) begin
            valid <= !(snoop_valid && same_granule(snoop_addr, set_addr, GRANULE_LOG2));
            resv_addr <= set_addr;
        end else if (clear || snoop_kill) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/amo_sequencer.sv
// amo_sequencer: LR/SC/AMO read-modify-write sequencer using the shared ALU AMO datapath
module amo_sequencer
    import amo_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int ADDR_WIDTH        = 64,
    parameter int RESV_GRANULE_LOG2 = 3
) (
    input logic            clk,
    input logic            rst,
    amo_sequencer_if.slave bus
);

    state_t                state, nstate;
    req_kind_t             kind_q;
    logic [4:0]            op_q;
    logic                  word_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] rdat_q;
    logic                  fault_q;
    logic                  accept;
    logic                  misaligned;
    logic                  rsp_take;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [ADDR_WIDTH-1:0] resv_addr;
    logic                  resv_match;
    logic                  resv_set;
    logic                  resv_clear;

    // acceptance, alignment, load extension and reservation control
    always_comb begin
        accept = state == S_IDLE && bus.req_valid;
        misaligned = bus.req_word ? |bus.req_addr[1:0] : |bus.req_addr[2:0];
        rsp_take = state == S_RD_WAIT && bus.mem_rsp_valid;
        rd_old = word_q ? {{(DATA_WIDTH-32){bus.mem_rsp_rdata[31]}}, bus.mem_rsp_rdata[31:0]} : bus.mem_rsp_rdata;
        resv_addr = state == S_IDLE ? bus.req_addr : addr_q;
        resv_set = rsp_take && kind_q == KIND_LR;
        resv_clear = (accept && !misaligned && bus.req_kind == KIND_SC)
                   || (state == S_WR_REQ && bus.mem_req_ready && kind_q == KIND_AMO && resv_match);
    end

    amo_reservation #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .GRANULE_LOG2(RESV_GRANULE_LOG2)
    ) u_resv (
        .clk        (clk),
        .rst        (rst),
        .set        (resv_set),
        .clear      (resv_clear),
        .set_addr   (addr_q),
        .match_addr (resv_addr),
        .snoop_valid(bus.snoop_valid),
        .snoop_addr (bus.snoop_addr),
        .valid      (bus.resv_valid),
        .match      (resv_match)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= nstate;
    end

    // next-state logic; SC success is decided at acceptance from the reservation match
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:    if (bus.req_valid) nstate = misaligned ? S_RESP :
                                                   bus.req_kind != KIND_SC ? S_RD_REQ :
                                                   resv_match ? S_WR_REQ : S_RESP;
            S_RD_REQ:  if (bus.mem_req_ready) nstate = S_RD_WAIT;
            S_RD_WAIT: if (bus.mem_rsp_valid) nstate = kind_q == KIND_LR ? S_RESP : S_WR_REQ;
            S_WR_REQ:  if (bus.mem_req_ready) nstate = S_RESP;
            S_RESP:    if (bus.resp_ready) nstate = S_IDLE;
            default:   nstate = S_IDLE;
        endcase
    end

    // request latch and rd data: SC fail returns 1, loads and AMOs return the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q <= KIND_LR;
            op_q <= '0;
            word_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rd_q <= '0;
            old_q <= '0;
            rdat_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                kind_q <= bus.req_kind;
                op_q <= bus.req_amo_op;
                word_q <= bus.req_word;
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
                rd_q <= bus.req_rd;
                fault_q <= misaligned;
                rdat_q <= {{(DATA_WIDTH-1){1'b0}}, !misaligned && bus.req_kind == KIND_SC && !resv_match};
            end
            if (rsp_take) begin
                old_q <= rd_old;
                rdat_q <= rd_old;
            end
        end
    end

    // outputs decoded from state and latched registers
    always_comb begin
        bus.req_ready = state == S_IDLE;
        bus.mem_req_valid = state == S_RD_REQ || state == S_WR_REQ;
        bus.mem_req_we = state == S_WR_REQ;
        bus.mem_req_word = word_q;
        bus.mem_req_addr = addr_q;
        bus.mem_req_wdata = state != S_WR_REQ ? '0 : kind_q == KIND_SC ? data_q : bus.alu_result;
        bus.alu_operand_a = old_q;
        bus.alu_operand_b = data_q;
        bus.alu_amo_op = op_q;
        bus.alu_word = word_q;
        bus.resp_valid = state == S_RESP;
        bus.resp_rd = rd_q;
        bus.resp_data = rdat_q;
        bus.resp_fault = state == S_RESP && fault_q;
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: directed and randomized checks of amo_sequencer against a transaction-level model
module tb_amo_sequencer;
    import amo_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    amo_sequencer_if bus ();

    amo_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b, input logic [4:0] op, input logic w);
        logic [63:0] x, y, r;
        x = w ? sx32(a[31:0]) : a;
        y = w ? sx32(b[31:0]) : b;
        case (op)
            AMO_ADD:  r = x + y;
            AMO_SWAP: r = y;
            AMO_XOR:  r = x ^ y;
            AMO_OR:   r = x | y;
            AMO_AND:  r = x & y;
            AMO_MIN:  r = $signed(x) < $signed(y) ? x : y;
            AMO_MAX:  r = $signed(x) > $signed(y) ? x : y;
            AMO_MINU: r = x < y ? x : y;
            AMO_MAXU: r = x > y ? x : y;
            default:  r = 64'h0;
        endcase
        return w ? sx32(r[31:0]) : r;
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_operand_a, bus.alu_operand_b, bus.alu_amo_op, bus.alu_word);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [63:0] sim_mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    int          rsp_lag = 0;
    bit          ready_rand = 0;
    int          writes = 0;
    int          rd_hs = 0;
    int          mreq_cycles = 0;
    logic [63:0] last_wa, last_wd;

    initial begin
        logic hs, hs_we, hs_w;
        logic [63:0] ha, hd, rv;
        int cnt;
        cnt = -1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            hs = bus.mem_req_valid && bus.mem_req_ready;
            hs_we = bus.mem_req_we;
            hs_w = bus.mem_req_word;
            ha = bus.mem_req_addr;
            hd = bus.mem_req_wdata;
            if (bus.mem_req_valid) mreq_cycles++;
            @(posedge clk);
            #1;
            bus.mem_rsp_valid = 1'b0;
            if (hs && hs_we) begin
                writes++;
                last_wa = ha;
                last_wd = hd;
                sim_mem[ha] = hs_w ? {32'h0, hd[31:0]} : hd;
            end
            if (hs && !hs_we) begin
                rd_hs++;
                cnt = rsp_lag;
                rv = sim_mem.exists(ha) ? sim_mem[ha] : 64'h0;
            end
            if (cnt == 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = rv;
            end
            if (cnt >= 0) cnt--;
            bus.mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic        m_resv_v = 1'b0;
    logic [63:0] m_resv_a = 64'h0;

    function automatic logic [63:0] gran(input logic [63:0] a);
        return a >> 3;
    endfunction

    function automatic logic [63:0] load(input logic [63:0] a, input logic w);
        logic [63:0] v;
        v = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
        return w ? sx32(v[31:0]) : v;
    endfunction

    task automatic mem_init(input logic [63:0] a, input logic [63:0] v);
        sim_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic snoop_idle(input logic [63:0] sa);
        @(negedge clk);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr = sa;
        @(posedge clk);
        #1;
        bus.snoop_valid = 1'b0;
        if (m_resv_v && gran(sa) == gran(m_resv_a)) m_resv_v = 1'b0;
    endtask

    task automatic run_txn(input req_kind_t k, input logic [4:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic snp, input logic [63:0] sa,
                           output int lat, output logic [63:0] rdat);
        logic [63:0] exp_rd, exp_wd, old;
        logic exp_f, exp_wr, ok;
        logic [4:0] rd;
        int w0;
        rd = 5'($urandom_range(1, 31));
        exp_f = w ? a[1:0] != 2'b0 : a[2:0] != 3'b0;
        exp_wr = 1'b0;
        exp_wd = 64'h0;
        exp_rd = 64'h0;
        if (snp && m_resv_v && gran(sa) == gran(m_resv_a)) m_resv_v = 1'b0;
        if (!exp_f) begin
            case (k)
                KIND_LR: begin
                    exp_rd = load(a, w);
                    m_resv_v = 1'b1;
                    m_resv_a = a;
                end
                KIND_SC: begin
                    ok = m_resv_v && gran(a) == gran(m_resv_a);
                    m_resv_v = 1'b0;
                    exp_rd = ok ? 64'h0 : 64'h1;
                    exp_wr = ok;
                    exp_wd = d;
                end
                default: begin
                    old = load(a, w);
                    exp_wd = alu_ref(old, d, op, w);
                    exp_wr = 1'b1;
                    exp_rd = old;
                    if (m_resv_v && gran(a) == gran(m_resv_a)) m_resv_v = 1'b0;
                end
            endcase
            if (exp_wr) ref_mem[a] = w ? {32'h0, exp_wd[31:0]} : exp_wd;
        end
        w0 = writes;
        @(negedge clk);
        check("req_ready_before", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 1'b1;
        bus.req_kind = k;
        bus.req_amo_op = op;
        bus.req_word = w;
        bus.req_addr = a;
        bus.req_data = d;
        bus.req_rd = rd;
        bus.snoop_valid = snp;
        bus.snoop_addr = sa;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.snoop_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdat = bus.resp_data;
        check("resp_valid", 64'(bus.resp_valid), 64'h1);
        check("resp_rd", 64'(bus.resp_rd), 64'(rd));
        check("resp_data", bus.resp_data, exp_rd);
        check("resp_fault", 64'(bus.resp_fault), 64'(exp_f));
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            check("resp_hold", {bus.resp_data[62:0], bus.resp_valid}, {exp_rd[62:0], 1'b1});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("back_to_idle", 64'(bus.req_ready), 64'h1);
        check("write_count", 64'(writes - w0), 64'(exp_wr));
        if (exp_wr) begin
            check("write_addr", last_wa, a);
            check("write_data", w ? {32'h0, last_wd[31:0]} : last_wd, w ? {32'h0, exp_wd[31:0]} : exp_wd);
        end
        check("resv_valid", 64'(bus.resv_valid), 64'(m_resv_v));
    endtask

    logic [63:0] pool [6] = '{64'h1000, 64'h1008, 64'h3000, 64'h3004, 64'h2000, 64'h1002};
    logic [4:0]  ops [9] = '{AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};

    initial begin
        int lat, m0, w0, r0, n;
        logic [63:0] rdat;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_kind = KIND_LR;
        bus.req_amo_op = '0;
        bus.req_word = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_rd = '0;
        bus.snoop_valid = 1'b0;
        bus.snoop_addr = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'h1);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("rst_resv_valid", 64'(bus.resv_valid), 64'h0);
        check("rst_alu_a", bus.alu_operand_a, 64'h0);
        check("rst_mem_addr", bus.mem_req_addr, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        mem_init(64'h1000, 64'd5);
        run_txn(KIND_AMO, AMO_ADD, 1'b0, 64'h1000, 64'd7, 1'b0, 64'h0, lat, rdat);
        check("amoadd_lat", 64'(lat), 64'd4);
        check("amoadd_rd", rdat, 64'd5);
        check("amoadd_wdata", last_wd, 64'd12);

        mem_init(64'h2004, 64'h8000_0000);
        run_txn(KIND_AMO, AMO_SWAP, 1'b1, 64'h2004, 64'd1, 1'b0, 64'h0, lat, rdat);
        check("amoswapw_rd", rdat, 64'hFFFF_FFFF_8000_0000);
        check("amoswapw_wdata", {32'h0, last_wd[31:0]}, 64'd1);

        mem_init(64'h3000, 64'h55);
        run_txn(KIND_LR, AMO_LR, 1'b0, 64'h3000, 64'h0, 1'b0, 64'h0, lat, rdat);
        check("lr_lat", 64'(lat), 64'd3);
        check("lr_rd", rdat, 64'h55);
        run_txn(KIND_SC, AMO_SC, 1'b0, 64'h3000, 64'hAB, 1'b0, 64'h0, lat, rdat);
        check("sc_ok_lat", 64'(lat), 64'd2);
        check("sc_ok_rd", rdat, 64'h0);
        check("sc_ok_wdata", last_wd, 64'hAB);

        run_txn(KIND_LR, AMO_LR, 1'b0, 64'h3000, 64'h0, 1'b0, 64'h0, lat, rdat);
        snoop_idle(64'h3004);
        run_txn(KIND_SC, AMO_SC, 1'b0, 64'h3000, 64'hCD, 1'b0, 64'h0, lat, rdat);
        check("sc_snooped_lat", 64'(lat), 64'd1);
        check("sc_snooped_rd", rdat, 64'h1);

        run_txn(KIND_LR, AMO_LR, 1'b0, 64'h3000, 64'h0, 1'b0, 64'h0, lat, rdat);
        run_txn(KIND_SC, AMO_SC, 1'b0, 64'h3000, 64'hEF, 1'b1, 64'h3000, lat, rdat);
        check("sc_snoop_same_cycle_rd", rdat, 64'h1);

        m0 = mreq_cycles;
        run_txn(KIND_AMO, AMO_OR, 1'b0, 64'h1003, 64'h1, 1'b0, 64'h0, lat, rdat);
        check("fault_lat", 64'(lat), 64'd1);
        check("fault_no_mem", 64'(mreq_cycles - m0), 64'h0);

        rsp_lag = 4;
        r0 = rd_hs;
        w0 = writes;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind = KIND_AMO;
        bus.req_amo_op = AMO_ADD;
        bus.req_word = 1'b0;
        bus.req_addr = 64'h1000;
        bus.req_data = 64'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (rd_hs == r0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid_read_issued", 64'(rd_hs - r0), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        m_resv_v = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("rst_mid_quiet", {62'h0, bus.resp_valid, bus.mem_req_valid}, 64'h0);
        end
        check("rst_mid_no_write", 64'(writes - w0), 64'h0);
        check("rst_mid_idle", 64'(bus.req_ready), 64'h1);
        check("rst_mid_resv", 64'(bus.resv_valid), 64'h0);
        rsp_lag = 0;

        foreach (pool[i]) mem_init(pool[i], {$urandom, $urandom});
        ready_rand = 1;
        for (int i = 0; i < 150; i++) begin
            req_kind_t k;
            logic [63:0] a, sa;
            logic snp;
            k = req_kind_t'($urandom_range(0, 2));
            a = pool[$urandom_range(0, 5)];
            sa = pool[$urandom_range(0, 5)];
            snp = k == KIND_SC && $urandom_range(0, 3) == 0;
            rsp_lag = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) snoop_idle(pool[$urandom_range(0, 5)]);
            run_txn(k, ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, snp, sa, lat, rdat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
